// File: rtl/fir_pkg.sv
// Shared types and constant helpers for the parametrised FIR section.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } ld_state_t;

  // Width of the coefficient word index; never narrower than one bit.
  function automatic int idx_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  // Half an LSB of the output scale, added before the arithmetic shift.
  function automatic longint rnd_const(input int frac);
    return (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
  endfunction

  // Saturation limits for a signed output of width w.
  function automatic longint sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient loader: serial words fill a shadow bank, which is copied to the
// active bank in a single COMMIT cycle so the datapath never sees a mix.
//
// state  | meaning
// IDLE   | waiting for c0, coef_ready=1
// LOAD   | accepting c1..c(TAPS-1), coef_ready=1
// COMMIT | active <= shadow, coef_ready=0
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int TAPS   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_coef_valid,
  input  logic [COEF_W-1:0]      i_coef_data,
  output logic                   o_coef_ready,
  output logic [TAPS*COEF_W-1:0] o_active
);

  localparam int IDX_W = idx_width(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  ld_state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic                   w_shadow_we;
  logic                   w_commit;
  logic [COEF_W-1:0]      r_shadow [TAPS];
  logic [TAPS*COEF_W-1:0] r_active;

  // State and word index registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state, index advance, shadow write strobe and commit strobe.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shadow_we  = 1'b0;
    w_commit     = 1'b0;
    o_coef_ready = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (i_coef_valid) begin
          w_shadow_we = 1'b1;
          if (TAPS == 1) begin
            w_state_nxt = ST_COMMIT;
          end else begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = IDX_W'(1);
          end
        end
      end
      ST_LOAD: begin
        if (i_coef_valid) begin
          w_shadow_we = 1'b1;
          if (r_idx == LAST_IDX) w_state_nxt = ST_COMMIT;
          else                   w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      ST_COMMIT: begin
        o_coef_ready = 1'b0;
        w_commit     = 1'b1;
        w_idx_nxt    = '0;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Shadow bank: written one word at a time at the current index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < TAPS; k++) r_shadow[k] <= '0;
    end else if (w_shadow_we) begin
      r_shadow[r_idx] <= i_coef_data;
    end
  end

  // Active bank: whole-bank copy on commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= '0;
    end else if (w_commit) begin
      for (int k = 0; k < TAPS; k++) r_active[k*COEF_W +: COEF_W] <= r_shadow[k];
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/fir_block_param.sv
// Cascadable direct-form FIR section with shadow-bank coefficient reload and a
// rounded, saturated output tap.
module fir_block_param
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 4,
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_x_in,
  input  logic [ACC_W-1:0]  i_y_in,
  input  logic              i_flush,
  input  logic              i_coef_valid,
  input  logic [COEF_W-1:0] i_coef_data,
  output logic              o_coef_ready,
  output logic [DATA_W-1:0] o_x_out,
  output logic [ACC_W-1:0]  o_y_out,
  output logic [DATA_W-1:0] o_y_dat,
  output logic              o_out_valid,
  output logic              o_sat
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(rnd_const(FRAC_BITS));
  localparam logic signed [ACC_W:0] HI  = (ACC_W + 1)'(sat_hi(DATA_W));
  localparam logic signed [ACC_W:0] LO  = (ACC_W + 1)'(sat_lo(DATA_W));

  logic [TAPS*COEF_W-1:0]    w_active;
  logic signed [DATA_W-1:0]  r_d      [TAPS];
  logic signed [DATA_W-1:0]  w_d_next [TAPS];
  logic signed [PROD_W-1:0]  w_prod   [TAPS];
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   r_y_out;
  logic [DATA_W-1:0]         r_x_out;
  logic                      r_upd;
  logic signed [ACC_W:0]     w_rnd;
  logic signed [ACC_W:0]     w_shift;
  logic                      w_hi;
  logic                      w_lo;
  logic [DATA_W-1:0]         w_y_sat;
  logic [DATA_W-1:0]         r_y_dat;
  logic                      r_sat;
  logic                      r_out_valid;

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_coef_bank (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_coef_valid (i_coef_valid),
    .i_coef_data  (i_coef_data),
    .o_coef_ready (o_coef_ready),
    .o_active     (w_active)
  );

  // Post-shift delay line and cascade sum; the incoming sample is tap 0.
  always_comb begin
    w_sum       = $signed(i_y_in);
    w_d_next[0] = $signed(i_x_in);
    for (int k = 1; k < TAPS; k++) w_d_next[k] = r_d[k-1];
    for (int k = 0; k < TAPS; k++) begin
      w_prod[k] = PROD_W'($signed(w_active[k*COEF_W +: COEF_W])) * PROD_W'(w_d_next[k]);
      w_sum     = w_sum + ACC_W'(w_prod[k]);
    end
  end

  // Delay line, cascade outputs and the update marker for the output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < TAPS; k++) r_d[k] <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_upd   <= 1'b0;
    end else if (i_flush) begin
      for (int k = 0; k < TAPS; k++) r_d[k] <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= i_in_valid;
      if (i_in_valid) begin
        r_d     <= w_d_next;
        r_x_out <= r_d[TAPS-1];
        r_y_out <= w_sum;
      end
    end
  end

  // Round half-up in one extra bit so the offset cannot wrap, then clamp.
  always_comb begin
    w_rnd   = $signed({r_y_out[ACC_W-1], r_y_out}) + RND;
    w_shift = w_rnd >>> FRAC_BITS;
    w_hi    = (w_shift > HI);
    w_lo    = (w_shift < LO);
    w_y_sat = w_hi ? HI[DATA_W-1:0] : (w_lo ? LO[DATA_W-1:0] : w_shift[DATA_W-1:0]);
  end

  // Registered output stage, one cycle behind each y_out update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y_dat     <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (i_flush) begin
      r_y_dat     <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_upd;
      if (r_upd) begin
        r_y_dat <= w_y_sat;
        r_sat   <= w_hi | w_lo;
      end
    end
  end

  assign o_x_out     = r_x_out;
  assign o_y_out     = r_y_out;
  assign o_y_dat     = r_y_dat;
  assign o_sat       = r_sat;
  assign o_out_valid = r_out_valid;

endmodule
